// File: rtl/noc_pkg.sv
// Shared definitions for the NoC input port: flit layout, encodings and XY routing.
package noc_pkg;

    // Default flit field widths
    localparam int DATA_BITS_DEF   = 32;
    localparam int APP_ID_BITS_DEF = 4;
    localparam int X_BITS_DEF      = 4;
    localparam int Y_BITS_DEF      = 4;
    localparam int TYPE_BITS_DEF   = 2;
    localparam int EXTRA_BITS_DEF  = 2;

    // Field offsets, LSB first: {EXTRA, TYPE, Y_ADDR, X_ADDR, APP_ID, DATA}
    localparam int DATA_OFF   = 0;
    localparam int APP_ID_OFF = DATA_OFF + DATA_BITS_DEF;
    localparam int X_OFF      = APP_ID_OFF + APP_ID_BITS_DEF;
    localparam int Y_OFF      = X_OFF + X_BITS_DEF;
    localparam int TYPE_OFF   = Y_OFF + Y_BITS_DEF;
    localparam int EXTRA_OFF  = TYPE_OFF + TYPE_BITS_DEF;
    localparam int FLIT_BITS_DEF = EXTRA_OFF + EXTRA_BITS_DEF;

    typedef enum logic [1:0] {
        FLIT_SINGLE = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_BODY   = 2'b10,
        FLIT_TAIL   = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ip_state_e;

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic port_e xy_route(input int dest_x, input int dest_y,
                                       input int my_x, input int my_y);
        port_e p;
        if (dest_x > my_x)      p = PORT_EAST;
        else if (dest_x < my_x) p = PORT_WEST;
        else if (dest_y > my_y) p = PORT_NORTH;
        else if (dest_y < my_y) p = PORT_SOUTH;
        else                    p = PORT_LOCAL;
        return p;
    endfunction

endpackage

// File: rtl/noc_input_port_fifo.sv
// flit_fifo: small circular buffer exposing its occupancy and the head entry.
module flit_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count < CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap at DEPTH so non-power-of-two depths also work.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy tracking; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_input_port.sv
// noc_input_port: buffered router input with XY route computation, packet
// tracking (route locked from HEAD until TAIL) and sticky protocol-error flag.
module noc_input_port
    import noc_pkg::*;
#(
    parameter int DATA_BITS     = 32,
    parameter int APP_ID_BITS   = 4,
    parameter int X_BITS        = 4,
    parameter int Y_BITS        = 4,
    parameter int TYPE_BITS     = 2,
    parameter int EXTRA_BITS    = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int OUT_PORT_BITS = 3,
    parameter int MY_X          = 1,
    parameter int MY_Y          = 1,
    localparam int FLIT_BITS = EXTRA_BITS + TYPE_BITS + Y_BITS + X_BITS + APP_ID_BITS + DATA_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ON,
    input  logic                     in_valid,
    input  logic [FLIT_BITS-1:0]     in_flit,
    output logic                     in_ready,
    output logic                     request,
    output logic [OUT_PORT_BITS-1:0] req_port,
    input  logic                     grant,
    output logic                     out_valid,
    output logic [FLIT_BITS-1:0]     out_flit,
    output logic                     err
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int X_LSB   = DATA_BITS + APP_ID_BITS;
    localparam int Y_LSB   = X_LSB + X_BITS;
    localparam int T_LSB   = Y_LSB + Y_BITS;

    logic [CNT_W-1:0]     w_count;
    logic [FLIT_BITS-1:0] w_head;
    logic [TYPE_BITS-1:0] w_type;
    logic [X_BITS-1:0]    w_dest_x;
    logic [Y_BITS-1:0]    w_dest_y;
    logic                 w_is_single;
    logic                 w_is_head;
    logic                 w_is_body;
    logic                 w_is_tail;
    port_e                w_route;
    port_e                w_port;
    logic                 w_legal;
    logic                 w_request;
    logic                 w_drop;
    logic                 w_load_route;
    logic                 w_push;
    logic                 w_pop;
    ip_state_e            r_state;
    ip_state_e            w_next_state;
    port_e                r_route;
    logic                 r_err;

    assign in_ready = (w_count < CNT_W'(FIFO_DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (w_request && grant) || w_drop;

    flit_fifo #(
        .WIDTH (FLIT_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (in_flit),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign w_type      = w_head[T_LSB +: TYPE_BITS];
    assign w_dest_x    = w_head[X_LSB +: X_BITS];
    assign w_dest_y    = w_head[Y_LSB +: Y_BITS];
    assign w_is_single = (w_type == TYPE_BITS'(FLIT_SINGLE));
    assign w_is_head   = (w_type == TYPE_BITS'(FLIT_HEAD));
    assign w_is_body   = (w_type == TYPE_BITS'(FLIT_BODY));
    assign w_is_tail   = (w_type == TYPE_BITS'(FLIT_TAIL));
    assign w_route     = xy_route(32'(w_dest_x), 32'(w_dest_y), MY_X, MY_Y);

    assign request   = w_request;
    assign req_port  = OUT_PORT_BITS'(w_port);
    assign out_valid = w_request && grant;
    assign out_flit  = w_head;
    assign err       = r_err;

    // Head-flit legality, arbitration request, error drop and next-state decode.
    always_comb begin
        w_next_state = r_state;
        w_request    = 1'b0;
        w_port       = PORT_LOCAL;
        w_drop       = 1'b0;
        w_load_route = 1'b0;
        w_legal      = 1'b0;
        if (w_count != '0) begin
            if (r_state == ST_IDLE) begin
                w_legal = w_is_single || w_is_head;
            end else begin
                w_legal = w_is_body || w_is_tail;
            end
            if (ON) begin
                if (w_legal) begin
                    w_request = 1'b1;
                    w_port    = (r_state == ST_IDLE) ? w_route : r_route;
                    if (grant) begin
                        if (r_state == ST_IDLE && w_is_head) begin
                            w_next_state = ST_ACTIVE;
                            w_load_route = 1'b1;
                        end else if (r_state == ST_ACTIVE && w_is_tail) begin
                            w_next_state = ST_IDLE;
                        end
                    end
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    // Packet state and the route locked in by a granted HEAD flit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_route <= PORT_LOCAL;
        end else begin
            r_state <= w_next_state;
            if (w_load_route) begin
                r_route <= w_route;
            end
        end
    end

    // Error flag stays set from the first dropped out-of-sequence flit until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_input_port.sv
// Directed self-checking bench for noc_input_port (MY_X=1, MY_Y=1, depth 4).
module tb_noc_input_port;
    import noc_pkg::*;

    localparam int FB = 48;

    logic          clk;
    logic          reset;
    logic          ON;
    logic          in_valid;
    logic [FB-1:0] in_flit;
    logic          in_ready;
    logic          request;
    logic [2:0]    req_port;
    logic          grant;
    logic          out_valid;
    logic [FB-1:0] out_flit;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;

    noc_input_port dut (
        .clk       (clk),
        .reset     (reset),
        .ON        (ON),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .request   (request),
        .req_port  (req_port),
        .grant     (grant),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FB-1:0] mk(input logic [1:0] t, input logic [3:0] x,
                                         input logic [3:0] y, input logic [31:0] d);
        return {2'b00, t, y, x, 4'h3, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ON = 1'b0; in_valid = 1'b0; in_flit = '0; grant = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (request !== 1'b0) $display("[TB] FAIL rst_request: got %b want 0", request); else n_pass++;
        n_checks++; if (req_port !== 3'd0) $display("[TB] FAIL rst_req_port: got %0d want 0", req_port); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("[TB] FAIL rst_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_single();
        logic [FB-1:0] f;
        f = mk(2'b00, 4'd3, 4'd1, 32'hA5A5_0001);
        ON = 1'b1; grant = 1'b1; in_valid = 1'b1; in_flit = f;
        #1;
        n_checks++; if (request !== 1'b0) $display("[TB] FAIL single_empty_req: got %b want 0", request); else n_pass++;
        step();
        in_valid = 1'b0;
        #1;
        n_checks++; if (request !== 1'b1) $display("[TB] FAIL single_req: got %b want 1", request); else n_pass++;
        n_checks++; if (req_port !== 3'd2) $display("[TB] FAIL single_port: got %0d want 2", req_port); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL single_out_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_flit !== f) $display("[TB] FAIL single_flit: got %h want %h", out_flit, f); else n_pass++;
        step();
        n_checks++; if (dut.w_count !== 3'd0) $display("[TB] FAIL single_drained: got %0d want 0", dut.w_count); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL single_idle_ov: got %b want 0", out_valid); else n_pass++;
        grant = 1'b0;
    endtask

    task automatic test_packet();
        logic [FB-1:0] fl [3];
        fl[0] = mk(2'b01, 4'd1, 4'd0, 32'h1111_0000);
        fl[1] = mk(2'b10, 4'd1, 4'd0, 32'h2222_0000);
        fl[2] = mk(2'b11, 4'd1, 4'd0, 32'h3333_0000);
        grant = 1'b0; ON = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_flit = fl[i];
            step();
        end
        in_valid = 1'b0;
        #1;
        n_checks++; if (req_port !== 3'd3) $display("[TB] FAIL pkt_wait_port: got %0d want 3", req_port); else n_pass++;
        step();
        n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL pkt_wait_ov: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (dut.w_count !== 3'd3) $display("[TB] FAIL pkt_count: got %0d want 3", dut.w_count); else n_pass++;
        grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL pkt_ov%0d: got %b want 1", i, out_valid); else n_pass++;
            n_checks++; if (req_port !== 3'd3) $display("[TB] FAIL pkt_port%0d: got %0d want 3", i, req_port); else n_pass++;
            n_checks++; if (out_flit !== fl[i]) $display("[TB] FAIL pkt_flit%0d: got %h want %h", i, out_flit, fl[i]); else n_pass++;
            step();
            if (i == 0) begin
                n_checks++; if (dut.r_state !== ST_ACTIVE) $display("[TB] FAIL pkt_active: got %0d want 1", dut.r_state); else n_pass++;
            end
        end
        n_checks++; if (dut.r_state !== ST_IDLE) $display("[TB] FAIL pkt_idle: got %0d want 0", dut.r_state); else n_pass++;
        n_checks++; if (request !== 1'b0) $display("[TB] FAIL pkt_end_req: got %b want 0", request); else n_pass++;
        grant = 1'b0;
    endtask

    task automatic test_full();
        logic [FB-1:0] fl [5];
        for (int i = 0; i < 5; i++) begin
            fl[i] = mk(2'b00, 4'd1, 4'd1, 32'hC000_0000 + 32'(i));
        end
        grant = 1'b0; ON = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_flit = fl[i];
            step();
        end
        n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL full_ready: got %b want 0", in_ready); else n_pass++;
        in_flit = fl[4];
        step();
        n_checks++; if (dut.w_count !== 3'd4) $display("[TB] FAIL full_no_take: got %0d want 4", dut.w_count); else n_pass++;
        grant = 1'b1;
        #1;
        n_checks++; if (out_flit !== fl[0]) $display("[TB] FAIL full_first: got %h want %h", out_flit, fl[0]); else n_pass++;
        step();
        grant = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL full_ready_again: got %b want 1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_checks++; if (dut.w_count !== 3'd4) $display("[TB] FAIL full_fifth_taken: got %0d want 4", dut.w_count); else n_pass++;
        grant = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #1;
            n_checks++; if (out_flit !== fl[i]) $display("[TB] FAIL full_order%0d: got %h want %h", i, out_flit, fl[i]); else n_pass++;
            step();
        end
        n_checks++; if (dut.w_count !== 3'd0) $display("[TB] FAIL full_drained: got %0d want 0", dut.w_count); else n_pass++;
        grant = 1'b0;
    endtask

    task automatic test_error();
        ON = 1'b1; grant = 1'b1;
        in_valid = 1'b1; in_flit = mk(2'b10, 4'd2, 4'd2, 32'hBAD0_0001);
        step();
        in_valid = 1'b0;
        #1;
        n_checks++; if (request !== 1'b0) $display("[TB] FAIL err_req: got %b want 0", request); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL err_ov: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("[TB] FAIL err_early: got %b want 0", err); else n_pass++;
        step();
        n_checks++; if (dut.w_count !== 3'd0) $display("[TB] FAIL err_dropped: got %0d want 0", dut.w_count); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("[TB] FAIL err_set: got %b want 1", err); else n_pass++;
        n_checks++; if (dut.r_state !== ST_IDLE) $display("[TB] FAIL err_state: got %0d want 0", dut.r_state); else n_pass++;
        step();
        step();
        n_checks++; if (err !== 1'b1) $display("[TB] FAIL err_sticky: got %b want 1", err); else n_pass++;
        grant = 1'b0;
    endtask

    task automatic test_on_hold();
        ON = 1'b0; grant = 1'b1;
        in_valid = 1'b1; in_flit = mk(2'b01, 4'd0, 4'd1, 32'h0DDC_0001);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (request !== 1'b0) $display("[TB] FAIL hold_req%0d: got %b want 0", i, request); else n_pass++;
            n_checks++; if (dut.w_count !== 3'd1) $display("[TB] FAIL hold_count%0d: got %0d want 1", i, dut.w_count); else n_pass++;
            step();
        end
        ON = 1'b1;
        #1;
        n_checks++; if (request !== 1'b1) $display("[TB] FAIL hold_on_req: got %b want 1", request); else n_pass++;
        n_checks++; if (req_port !== 3'd4) $display("[TB] FAIL hold_on_port: got %0d want 4", req_port); else n_pass++;
        step();
        n_checks++; if (dut.r_state !== ST_ACTIVE) $display("[TB] FAIL hold_active: got %0d want 1", dut.r_state); else n_pass++;
        grant = 1'b0;
    endtask

    task automatic test_reset_active();
        ON = 1'b1; grant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_flit = mk(2'b10, 4'd0, 4'd1, 32'hB0D0_0000 + 32'(i));
            step();
        end
        in_valid = 1'b0;
        #1;
        n_checks++; if (dut.w_count !== 3'd2) $display("[TB] FAIL ra_count_pre: got %0d want 2", dut.w_count); else n_pass++;
        n_checks++; if (req_port !== 3'd4) $display("[TB] FAIL ra_locked_port: got %0d want 4", req_port); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (dut.w_count !== 3'd0) $display("[TB] FAIL ra_count: got %0d want 0", dut.w_count); else n_pass++;
        n_checks++; if (dut.r_state !== ST_IDLE) $display("[TB] FAIL ra_state: got %0d want 0", dut.r_state); else n_pass++;
        n_checks++; if (request !== 1'b0) $display("[TB] FAIL ra_req: got %b want 0", request); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL ra_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("[TB] FAIL ra_err: got %b want 0", err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_packet();
        test_full();
        test_error();
        test_on_hold();
        test_reset_active();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
